// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder.
//   state_e    : responder FSM encoding
//   WORD_W     : instruction word width
//   INSTR_NOP  : word returned on a faulting fetch
package imem_responder_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] INSTR_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage : imem_responder_pkg

// File: rtl/imem_responder_if.sv
// Fetch request/response handshake bundle between the fetch stage and the responder.
//   req_valid/req_ready/req_addr         : fetch request channel
//   resp_valid/resp_ready/resp_instr/err : fetch response channel
// master = fetch stage, slave = responder.
interface imem_responder_if #(
    parameter int unsigned ADDR_W = 32
) ();
    import imem_responder_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [WORD_W-1:0] resp_instr;
    logic              resp_err;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_instr, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_instr, resp_err
    );

endinterface : imem_responder_if

// File: rtl/imem_responder_array.sv
// Program word storage: one write port and one registered read port.
//   clk, rst            : clock, sync active-high reset (read register only)
//   we_i/waddr_i/wdata_i: word write
//   re_i/raddr_i        : read strobe and word index, result lands in rdata_o
//   rzero_i             : on a read, return INSTR_NOP instead of the stored word
//   rdata_o             : registered read data, held between reads
module imem_array
    import imem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic              rzero_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read samples the pre-write value when both hit the same word on one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= INSTR_NOP;
        end else if (re_i) begin
            rdata_q <= rzero_i ? INSTR_NOP : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : imem_array

// File: rtl/imem_responder.sv
// Instruction-memory responder: serves fetches with WAIT_CYCLES wait states,
// flags misaligned / out-of-range fetches, and accepts array loads at any time.
//   clk, rst                     : clock, sync active-high reset
//   bus (slave)                  : fetch request/response handshake
//   load_en/load_addr/load_data  : word load port (bad addresses dropped)
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    imem_responder_if.slave   bus,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [WORD_W-1:0] load_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH * 4);

    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || (a >= ADDR_LIMIT);
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;

    logic [ADDR_W-1:0] rd_addr_c;
    logic              rd_bad_c;
    logic              rd_en_c;
    logic              load_ok_c;

    // With zero wait states the read fires on the accept edge, before addr_q holds the address.
    assign rd_addr_c = (state_q == IDLE) ? bus.req_addr : addr_q;
    assign rd_bad_c  = addr_bad(rd_addr_c);
    assign load_ok_c = load_en && !addr_bad(load_addr);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Next-state logic; outputs derive from the next state so they stay registered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rd_en_c    = 1'b0;
        resp_err_d = resp_err_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    addr_d = bus.req_addr;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        rd_en_c = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(WAIT_CYCLES)) begin
                    state_d = RESP;
                    rd_en_c = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (rd_en_c) begin
            resp_err_d = rd_bad_c;
        end

        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
    end

    logic [WORD_W-1:0] rdata_c;

    imem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (load_ok_c),
        .waddr_i (load_addr[IDX_W+1:2]),
        .wdata_i (load_data),
        .re_i    (rd_en_c),
        .rzero_i (rd_bad_c),
        .raddr_i (rd_addr_c[IDX_W+1:2]),
        .rdata_o (rdata_c)
    );

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_instr = rdata_c;

endmodule : imem_responder

// File: doc/imem_responder.md
Name: imem_responder

Overview:
Instruction-memory responder that serves fetch requests from the fetch stage over a valid/ready request and response handshake.
It holds program words in an internal word array with a programmable wait-state latency, and flags misaligned or out-of-range fetches.
A separate load port fills the array from the testbench or boot logic.
It replaces the zero-latency combinational instruction memory once fetch becomes multi-cycle.

Parameters:
DEPTH, 256, number of 32-bit words stored; byte address range 0 .. DEPTH*4-1
WAIT_CYCLES, 2, wait states between request acceptance and response; 0 is legal
ADDR_W, 32, request address width (byte address)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  fetch request present
req_ready  output  1  responder can accept a request this cycle
req_addr  input  ADDR_W  byte address of instruction (PC value)
resp_valid  output  1  response word available
resp_ready  input  1  fetch stage consumes response this cycle
resp_instr  output  32  fetched instruction word
resp_err  output  1  fetch fault: misaligned or out of range
load_en  input  1  write one word into array
load_addr  input  ADDR_W  byte address of word to write
load_data  input  32  word to write

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); it is sampled only on a clk rising edge.
- Reset values: state=IDLE, req_ready=1 in the cycle after reset, resp_valid=0, resp_instr=0, resp_err=0, wait counter=0.
- Array contents are NOT reset.
- FSM states:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch req_addr. Go to WAIT if WAIT_CYCLES>0, else RESP.
  - WAIT: req_ready=0. Counter counts up from 1. When the counter equals WAIT_CYCLES, go to RESP.
  - RESP: req_ready=0, resp_valid=1. resp_instr and resp_err stay stable until resp_ready. On resp_valid&&resp_ready, go to IDLE and clear resp_valid.
- Latency: a request accepted at edge T gives resp_valid=1 in cycle T+1+WAIT_CYCLES.
- Issue rate: there is no same-cycle re-accept after a response handshake, so the next acceptance is earliest one cycle later. Peak throughput is one fetch per WAIT_CYCLES+2 cycles.
- Data sample point: the array is read on the transition into RESP, using the latched address, and the result is registered into resp_instr.
- Error rules:
  - misaligned: latched_addr[1:0] != 0.
  - out of range: latched_addr >= DEPTH*4.
  - On either error: resp_err=1 and resp_instr=32'h0000_0000 (NOP). The response is still delivered through the normal handshake.
- Word index = latched_addr[log2(DEPTH)+1:2].
- Load port:
  - On load_en, write load_data at load_addr word index, from any state.
  - Writes with load_addr out of range or misaligned are silently dropped.
  - Load and read sample of the same word in the same cycle: the response carries the OLD word (read-before-write). The new word is visible to later fetches.
- req_valid while not in IDLE: ignored. The fetch stage must hold req_addr until it sees req_ready.
- resp_ready while not in RESP: ignored.
- Reset mid-operation: the in-flight request is dropped and no response is emitted. resp_valid drops in the cycle after the reset edge.
- WAIT_CYCLES=0: the WAIT state is never entered.

Decomposition:
- Shared package/include holds:
  - state encodings IDLE=2'd0, WAIT=2'd1, RESP=2'd2
  - INSTR_NOP=32'h0000_0000
  - word width 32
- Sub-module imem_array holds the storage: a single write port (load) and a synchronous read port with read-before-write. The responder contains only the FSM, counter, error check and output registers.

Test Plan:
- Load words 0x20080005 @0x0 and 0x21090003 @0x4. Request addr 0x0 at cycle 10, resp_ready=1 → resp_valid=1 at cycle 13 with resp_instr=0x20080005, resp_err=0 (WAIT_CYCLES=2).
- Request addr 0x6 → resp_err=1, resp_instr=0x00000000. Request 0x400 with DEPTH=256 → resp_err=1, resp_instr=0x00000000.
- Backpressure: resp_ready=0 for 5 cycles → resp_valid and resp_instr stay constant and req_ready=0 throughout. Raising resp_ready completes the handshake, and req_ready=1 in the following cycle.
- Same-cycle load of 0xDEADBEEF @0x4 as the RESP entry of a fetch to 0x4 → response 0x21090003. Next fetch of 0x4 → 0xDEADBEEF.
- Assert rst in a WAIT cycle → no resp_valid afterwards. A subsequent fetch of 0x0 returns 0x20080005 normally.
- WAIT_CYCLES=0 build: sequential fetches 0x0, 0x4, 0x8 give one response every 2 cycles, with latency 1 cycle after acceptance.
